cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter WORD_W, default 32, address and data width.
REQ-002 Parameter STARVE_MAX, default 4, max consecutive dcache grants completed while iREN is pending.
REQ-003 CLK  input  1  single clock, rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 iREN  input  1  icache read request.
REQ-006 iaddr  input  WORD_W  icache address.
REQ-007 iwait  output  1  icache stall; low only in the icache completing cycle.
REQ-008 iload  output  WORD_W  icache read data.
REQ-009 dREN  input  1  dcache read request.
REQ-010 dWEN  input  1  dcache write request.
REQ-011 daddr  input  WORD_W  dcache address.
REQ-012 dstore  input  WORD_W  dcache write data.
REQ-013 dwait  output  1  dcache stall; low only in the dcache completing cycle.
REQ-014 dload  output  WORD_W  dcache read data.
REQ-015 ramREN  output  1  memory read strobe.
REQ-016 ramWEN  output  1  memory write strobe.
REQ-017 ramaddr  output  WORD_W  memory address.
REQ-018 ramstore  output  WORD_W  memory write data.
REQ-019 ramload  input  WORD_W  memory read data.
REQ-020 ramstate  input  ramstate_t (2 bits)  FREE, BUSY, ACCESS, ERROR.

Function
REQ-021 FSM SHALL have states IDLE, IGNT and DGNT, registered on CLK.
REQ-022 IDLE: all ram strobes 0, ramaddr/ramstore 0, iwait=dwait=1, iload=dload=0.
REQ-023 IDLE -> DGNT when (dREN|dWEN) and (!iREN or starve_cnt < STARVE_MAX); else IDLE -> IGNT when iREN; else remain IDLE.
REQ-024 IGNT: ramREN=1, ramaddr=iaddr; dwait=1.
REQ-025 DGNT: ramREN=dREN&!dWEN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore; iwait=1.
REQ-026 dREN and dWEN both high: the write SHALL win; ramREN=0.
REQ-027 Completion: in a grant state with ramstate==ACCESS, the granted wait SHALL go 0 and the granted load SHALL equal ramload in that same cycle; next state IDLE.
REQ-028 iload/dload SHALL be 0 in every cycle except their own completing cycle.
REQ-029 ramstate BUSY, FREE or ERROR in a grant state: hold state, keep strobes asserted (ERROR = retry), wait stays 1.
REQ-030 Granted request deasserted before ACCESS: strobes drop combinationally that cycle, wait stays 1, next state IDLE.
REQ-031 Latency: minimum 2 cycles from request assertion to wait low; one IDLE cycle between consecutive grants is mandatory.
REQ-032 starve_cnt (clog2(STARVE_MAX+1) bits) SHALL increment, saturating at STARVE_MAX, on each DGNT completion with iREN high.
REQ-033 starve_cnt SHALL clear on IGNT completion, or in IDLE when iREN is low.
REQ-034 Requests from a cache arriving mid-grant of the other SHALL be held off (wait=1), never dropped.

Reset
REQ-035 RST high at a rising edge SHALL set state IDLE and starve_cnt 0; outputs take IDLE values from the next cycle.
REQ-036 Reset mid-grant SHALL abandon the transaction without a completing cycle; pending requests are re-arbitrated from IDLE after reset.

Structure
REQ-037 ramstate_t and arb_state_t SHALL live in cpu_types_pkg; STARVE_MAX stays a module parameter.
REQ-038 Single module, no sub-modules; FSM, counter and output mux inline; one registered process plus one combinational process.

Verification
REQ-039 Lone icache read: iREN=1, iaddr=0x40, ramstate ACCESS on the first IGNT cycle with ramload=0xDEADBEEF -> iwait low for 1 cycle on cycle 2, iload=0xDEADBEEF.
REQ-040 Simultaneous iREN and dWEN (daddr=0x80, dstore=0x1234): DGNT first, ramWEN=1, ramstore=0x1234; then IDLE, then IGNT.
REQ-041 Starvation: iREN held, dREN re-asserted back-to-back, STARVE_MAX=4 -> exactly 4 dcache completions, then an IGNT grant.
REQ-042 ramstate BUSY 3 cycles, ERROR 1, then ACCESS -> strobes held for all 5 grant cycles, wait low only on the 5th.
REQ-043 iREN dropped on the 2nd IGNT cycle while BUSY -> ramREN 0 that cycle, iwait never low, IDLE next cycle.
REQ-044 RST pulsed during a BUSY DGNT -> IDLE, starve_cnt 0, no completion; still-held dREN is re-granted after reset.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: memory handshake states and cache arbiter FSM states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates icache and dcache requests onto a single memory port. The dcache
// normally wins, but a pending icache read is granted after STARVE_MAX dcache transfers.
module cache_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  ramstate_t         ramstate
);

    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_t       state, next_state;
    logic [CNT_W-1:0] starve_cnt, next_cnt;
    logic             dreq;
    logic             ram_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign dreq     = dREN | dWEN;
    assign ram_done = (ramstate == ACCESS);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= next_cnt;
        end
    end

    // Every grant returns to IDLE, so consecutive grants are always separated
    // by one arbitration cycle; withdrawn requests release the port immediately.
    always_comb begin
        next_state = state;
        next_cnt   = starve_cnt;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        case (state)
            IDLE: begin
                if (!iREN) begin
                    next_cnt = '0;
                end
                if (dreq && (!iREN || (starve_cnt < CNT_MAX))) begin
                    next_state = DGNT;
                end else if (iREN) begin
                    next_state = IGNT;
                end
            end
            IGNT: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ram_done) begin
                        iwait      = 1'b0;
                        iload      = ramload;
                        next_state = IDLE;
                        next_cnt   = '0;
                    end
                end
            end
            DGNT: begin
                if (!dreq) begin
                    next_state = IDLE;
                end else begin
                    // A simultaneous read and write is treated as a write.
                    ramREN   = dREN & ~dWEN;
                    ramWEN   = dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ram_done) begin
                        dwait      = 1'b0;
                        dload      = ramload;
                        next_state = IDLE;
                        if (iREN) begin
                            next_cnt = sat_inc(starve_cnt);
                        end
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a transaction-level owner model.
module tb_cache_arbiter;
    import cpu_types_pkg::*;

    localparam int W          = 32;
    localparam int STARVE_MAX = 4;

    logic         CLK, RST;
    logic         iREN, dREN, dWEN;
    logic [W-1:0] iaddr, daddr, dstore, ramload;
    ramstate_t    ramstate;
    logic         iwait, dwait, ramREN, ramWEN;
    logic [W-1:0] iload, dload, ramaddr, ramstore;

    cache_arbiter #(.WORD_W(W), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic         iwait, dwait, ren, wen;
        logic [W-1:0] addr, store, iload, dload;
    } out_t;

    typedef struct packed {
        logic         iren, dren, dwen;
        logic [W-1:0] iaddr, daddr, dstore, rload;
        ramstate_t    rs;
        out_t         e;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Model: who currently owns the port (0 none, 1 icache, 2 dcache) and how
    // many dcache transfers finished in a row while the icache waited.
    int m_owner = 0, m_streak = 0;
    int n_owner, n_streak;

    vec_t      tbl[22];
    ramstate_t be_seq[5] = '{BUSY, BUSY, BUSY, ERROR, ACCESS};

    function automatic vec_t mkv(logic ir, logic dr, logic dw, logic [W-1:0] ia, logic [W-1:0] da,
                                 logic [W-1:0] ds, logic [W-1:0] rl, ramstate_t rs,
                                 logic iw, logic dwt, logic rn, logic wn, logic [W-1:0] ad,
                                 logic [W-1:0] st, logic [W-1:0] il, logic [W-1:0] dl);
        vec_t v;
        v.iren = ir; v.dren = dr; v.dwen = dw;
        v.iaddr = ia; v.daddr = da; v.dstore = ds; v.rload = rl; v.rs = rs;
        v.e = '{iw, dwt, rn, wn, ad, st, il, dl};
        return v;
    endfunction

    function automatic out_t model_out();
        out_t o;
        o = '0;
        o.iwait = 1'b1;
        o.dwait = 1'b1;
        if (m_owner == 1 && iREN) begin
            o.ren  = 1'b1;
            o.addr = iaddr;
            if (ramstate == ACCESS) begin
                o.iwait = 1'b0;
                o.iload = ramload;
            end
        end else if (m_owner == 2 && (dREN || dWEN)) begin
            o.wen   = dWEN;
            o.ren   = dREN && !dWEN;
            o.addr  = daddr;
            o.store = dstore;
            if (ramstate == ACCESS) begin
                o.dwait = 1'b0;
                o.dload = ramload;
            end
        end
        return o;
    endfunction

    function automatic void model_next();
        n_owner  = m_owner;
        n_streak = m_streak;
        if (RST) begin
            n_owner  = 0;
            n_streak = 0;
        end else if (m_owner == 0) begin
            if (!iREN) n_streak = 0;
            if ((dREN || dWEN) && (!iREN || m_streak < STARVE_MAX)) n_owner = 2;
            else if (iREN) n_owner = 1;
        end else if (m_owner == 1) begin
            if (!iREN) n_owner = 0;
            else if (ramstate == ACCESS) begin
                n_owner  = 0;
                n_streak = 0;
            end
        end else begin
            if (!(dREN || dWEN)) n_owner = 0;
            else if (ramstate == ACCESS) begin
                n_owner = 0;
                if (iREN) n_streak = (m_streak + 1 > STARVE_MAX) ? STARVE_MAX : m_streak + 1;
            end
        end
    endfunction

    task automatic check_out(input string tag, input out_t e);
        out_t a;
        a = '{iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload};
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got iw=%b dw=%b ren=%b wen=%b addr=%h st=%h il=%h dl=%h want iw=%b dw=%b ren=%b wen=%b addr=%h st=%h il=%h dl=%h",
                     tag, a.iwait, a.dwait, a.ren, a.wen, a.addr, a.store, a.iload, a.dload,
                     e.iwait, e.dwait, e.ren, e.wen, e.addr, e.store, e.iload, e.dload);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic set_in(input logic ir, input logic dr, input logic dw, input logic [W-1:0] ia,
                          input logic [W-1:0] da, input logic [W-1:0] ds,
                          input logic [W-1:0] rl, input ramstate_t rs);
        iREN = ir; dREN = dr; dWEN = dw;
        iaddr = ia; daddr = da; dstore = ds; ramload = rl; ramstate = rs;
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic advance();
        model_next();
        @(posedge CLK);
        m_owner  = n_owner;
        m_streak = n_streak;
        @(negedge CLK);
    endtask

    task automatic tick(input string tag);
        #1;
        check_out(tag, model_out());
        advance();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        set_in(0, 0, 0, '0, '0, '0, '0, FREE);
        advance();
        advance();
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn, igot;
        RST = 1'b0;
        set_in(0, 0, 0, '0, '0, '0, '0, FREE);
        @(negedge CLK);

        //                 ir dr dw iaddr   daddr   dstore  rload         rs      iw dw rn wn addr    store   iload         dload
        tbl[0]  = mkv(0, 0, 0, 'h0,  'h0,   'h0,    'h0,          FREE,   1, 1, 0, 0, 'h0,   'h0,    'h0,          'h0);
        tbl[1]  = mkv(1, 0, 0, 'h40, 'h0,   'h0,    'hDEADBEEF,   ACCESS, 1, 1, 0, 0, 'h0,   'h0,    'h0,          'h0);
        tbl[2]  = mkv(1, 0, 0, 'h40, 'h0,   'h0,    'hDEADBEEF,   ACCESS, 0, 1, 1, 0, 'h40,  'h0,    'hDEADBEEF,   'h0);
        tbl[3]  = mkv(0, 0, 0, 'h0,  'h0,   'h0,    'hDEADBEEF,   ACCESS, 1, 1, 0, 0, 'h0,   'h0,    'h0,          'h0);
        tbl[4]  = mkv(1, 0, 1, 'h44, 'h80,  'h1234, 'h0,          FREE,   1, 1, 0, 0, 'h0,   'h0,    'h0,          'h0);
        tbl[5]  = mkv(1, 0, 1, 'h44, 'h80,  'h1234, 'h55,         ACCESS, 1, 0, 0, 1, 'h80,  'h1234, 'h0,          'h55);
        tbl[6]  = mkv(1, 0, 0, 'h44, 'h0,   'h0,    'h0,          FREE,   1, 1, 0, 0, 'h0,   'h0,    'h0,          'h0);
        tbl[7]  = mkv(1, 0, 0, 'h44, 'h0,   'h0,    'h0,          BUSY,   1, 1, 1, 0, 'h44,  'h0,    'h0,          'h0);
        tbl[8]  = mkv(1, 0, 0, 'h44, 'h0,   'h0,    'h77,         ACCESS, 0, 1, 1, 0, 'h44,  'h0,    'h77,         'h0);
        tbl[9]  = mkv(0, 0, 0, 'h0,  'h0,   'h0,    'h0,          FREE,   1, 1, 0, 0, 'h0,   'h0,    'h0,          'h0);
        tbl[10] = mkv(0, 1, 1, 'h0,  'h90,  'hA5,   'h0,          FREE,   1, 1, 0, 0, 'h0,   'h0,    'h0,          'h0);
        tbl[11] = mkv(0, 1, 1, 'h0,  'h90,  'hA5,   'h99,         ACCESS, 1, 0, 0, 1, 'h90,  'hA5,   'h0,          'h99);
        tbl[12] = mkv(0, 1, 0, 'h0,  'h100, 'h0,    'h0,          FREE,   1, 1, 0, 0, 'h0,   'h0,    'h0,          'h0);
        tbl[13] = mkv(0, 1, 0, 'h0,  'h100, 'h0,    'h0,          ERROR,  1, 1, 1, 0, 'h100, 'h0,    'h0,          'h0);
        tbl[14] = mkv(0, 1, 0, 'h0,  'h100, 'h0,    'hCAFE,       ACCESS, 1, 0, 1, 0, 'h100, 'h0,    'h0,          'hCAFE);
        tbl[15] = mkv(0, 0, 0, 'h0,  'h0,   'h0,    'h0,          FREE,   1, 1, 0, 0, 'h0,   'h0,    'h0,          'h0);
        tbl[16] = mkv(1, 0, 0, 'h48, 'h0,   'h0,    'h0,          FREE,   1, 1, 0, 0, 'h0,   'h0,    'h0,          'h0);
        tbl[17] = mkv(1, 1, 0, 'h48, 'h104, 'h0,    'h0,          BUSY,   1, 1, 1, 0, 'h48,  'h0,    'h0,          'h0);
        tbl[18] = mkv(1, 1, 0, 'h48, 'h104, 'h0,    'h11,         ACCESS, 0, 1, 1, 0, 'h48,  'h0,    'h11,         'h0);
        tbl[19] = mkv(0, 1, 0, 'h0,  'h104, 'h0,    'h0,          FREE,   1, 1, 0, 0, 'h0,   'h0,    'h0,          'h0);
        tbl[20] = mkv(0, 1, 0, 'h0,  'h104, 'h0,    'h22,         ACCESS, 1, 0, 1, 0, 'h104, 'h0,    'h0,          'h22);
        tbl[21] = mkv(0, 0, 0, 'h0,  'h0,   'h0,    'h0,          FREE,   1, 1, 0, 0, 'h0,   'h0,    'h0,          'h0);

        // Directed vector table, starting from a freshly reset arbiter.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            set_in(tbl[i].iren, tbl[i].dren, tbl[i].dwen, tbl[i].iaddr, tbl[i].daddr,
                   tbl[i].dstore, tbl[i].rload, tbl[i].rs);
            #1;
            check_out($sformatf("vec%0d", i), tbl[i].e);
            advance();
        end

        // Starvation: icache held, dcache always requesting.
        do_reset();
        set_in(1, 1, 0, 'h300, 'h400, 'h0, 'h5A, ACCESS);
        dn = 0; igot = 0;
        for (int c = 0; c < 20 && igot == 0; c++) begin
            #1;
            if (!dwait) dn++;
            if (!iwait) igot = 1;
            check_out("starve", model_out());
            advance();
        end
        check_int("starve_icache_granted", igot, 1);
        check_int("starve_dcache_count", dn, STARVE_MAX);

        // BUSY x3, ERROR, ACCESS on a dcache read.
        do_reset();
        set_in(0, 1, 0, 'h0, 'h200, 'h9, 'h0, FREE);
        tick("be_idle");
        for (int k = 0; k < 5; k++) begin
            ramstate = be_seq[k];
            ramload  = W'('hB0 + k);
            #1;
            check_int($sformatf("be_strobe%0d", k), int'(ramREN), 1);
            check_int($sformatf("be_wait%0d", k), int'(dwait), (k == 4) ? 0 : 1);
            check_out("be_model", model_out());
            advance();
        end
        set_in(0, 0, 0, '0, '0, '0, '0, FREE);
        tick("be_after");

        // Icache request withdrawn mid-grant.
        do_reset();
        set_in(1, 0, 0, 'h500, 'h0, 'h0, 'h0, FREE);
        tick("drop_req");
        ramstate = BUSY;
        #1;
        check_int("drop_grant_strobe", int'(ramREN), 1);
        advance();
        iREN = 1'b0;
        #1;
        check_int("drop_strobe_low", int'(ramREN), 0);
        check_int("drop_iwait", int'(iwait), 1);
        check_out("drop_model", model_out());
        advance();
        iREN = 1'b1; ramstate = ACCESS; ramload = 'hEE;
        #1;
        check_int("drop_back_idle", int'(ramREN), 0);
        check_int("drop_no_done", int'(iwait), 1);
        advance();
        tick("drop_regrant");
        set_in(0, 0, 0, '0, '0, '0, '0, FREE);
        tick("drop_end");

        // Reset during a BUSY dcache grant with a partly built-up starvation count.
        do_reset();
        set_in(1, 1, 0, 'h600, 'h700, 'h0, 'h33, ACCESS);
        dn = 0;
        for (int c = 0; c < 12 && dn < 3; c++) begin
            #1;
            if (!dwait) dn++;
            check_out("rm_build", model_out());
            advance();
        end
        check_int("rm_build_count", dn, 3);
        ramstate = BUSY;
        tick("rm_idle");
        RST = 1'b1;
        #1;
        check_int("rm_no_done", int'(dwait), 1);
        check_out("rm_busy_grant", model_out());
        advance();
        RST = 1'b0;
        ramstate = ACCESS;
        dn = 0; igot = 0;
        for (int c = 0; c < 20 && igot == 0; c++) begin
            #1;
            if (!dwait) dn++;
            if (!iwait) igot = 1;
            check_out("rm_after", model_out());
            advance();
        end
        check_int("rm_regrant_dcount", dn, STARVE_MAX);
        check_int("rm_icache_granted", igot, 1);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) iREN = ~iREN;
            if ($urandom_range(0, 3) == 0) dREN = ~dREN;
            if ($urandom_range(0, 5) == 0) dWEN = ~dWEN;
            if ($urandom_range(0, 2) == 0) iaddr = $urandom;
            if ($urandom_range(0, 2) == 0) daddr = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramstate = ramstate_t'($urandom_range(0, 3));
            RST      = ($urandom_range(0, 79) == 0);
            tick("rand");
        end
        RST = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
